// File: rtl/client_rx_pkg.sv
// Shared definitions for the receive stream client: FSM state codes,
// storage entry width and pointer-width derivation.
package client_rx_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Buffer entry: {last, byte}
  localparam int unsigned ENTRY_W = 9;

  // Pointers carry one extra wrap bit beyond the buffer address.
  function automatic int unsigned ptr_width(input int unsigned jumbo_dw);
    return jumbo_dw + 1;
  endfunction

endpackage

// File: rtl/dpram_rx.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register holds its value while re is low.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port (rdata valid the cycle after re)
module dpram_rx #(
  parameter int unsigned aw = 14,
  parameter int unsigned dw = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [0:(1 << aw) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/client_rx_s.sv
// Receive-side stream client. Buffers each incoming packet speculatively,
// commits it only on a good CRC, and presents committed packets on a
// byte-wide AXI-stream master with m_tlast on the final byte.
//   clk, rst              : clock, async active-high reset
//   rx_ready              : start of a new packet
//   rx_strobe, data_in    : payload byte
//   rx_eop, rx_crc_ok     : end of packet and its CRC verdict
//   m_tdata/m_tvalid/m_tlast/m_tready : stream master
//   drop_cnt              : saturating dropped-packet count
//   overflow              : pulse when a packet is dropped for lack of space
module client_rx_s
  import client_rx_pkg::*;
#(
  parameter int unsigned JUMBO_DW = 14,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic             rx_strobe,
  input  logic [7:0]       data_in,
  input  logic             rx_eop,
  input  logic             rx_crc_ok,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam int unsigned     PW  = ptr_width(JUMBO_DW);
  localparam logic [PW-1:0]   CAP = PW'(1) << JUMBO_DW;

  logic [1:0]          state, state_n;
  logic [PW-1:0]       wr_spec, wr_spec_n;
  logic [PW-1:0]       wr_commit, wr_commit_n;
  logic [PW-1:0]       rd;
  logic [7:0]          hold, hold_n;
  logic                hold_v, hold_v_n;
  logic                we;
  logic [ENTRY_W-1:0]  wdata;
  logic                drop_inc;
  logic                ovf_n;
  logic                full;

  logic                rq_v;
  logic                out_load;
  logic                rd_en;
  logic [ENTRY_W-1:0]  rq_data;

  assign full = ((wr_spec - rd) == CAP);

  // Write side. Priority within RECV: rx_ready, then rx_eop, then rx_strobe.
  always_comb begin
    state_n     = state;
    wr_spec_n   = wr_spec;
    wr_commit_n = wr_commit;
    hold_n      = hold;
    hold_v_n    = hold_v;
    we          = 1'b0;
    wdata       = '0;
    drop_inc    = 1'b0;
    ovf_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_ready) begin
          state_n  = ST_RECV;
          hold_v_n = 1'b0;
        end
      end
      ST_RECV: begin
        if (rx_ready) begin
          if (hold_v) begin
            wr_spec_n = wr_commit;
            drop_inc  = 1'b1;
          end
          hold_v_n = 1'b0;
        end else if (rx_eop) begin
          state_n  = ST_IDLE;
          hold_v_n = 1'b0;
          if (hold_v) begin
            if (!rx_crc_ok) begin
              wr_spec_n = wr_commit;
              drop_inc  = 1'b1;
            end else if (full) begin
              // Final held byte has nowhere to go: treat as an overflow drop.
              wr_spec_n = wr_commit;
              drop_inc  = 1'b1;
              ovf_n     = 1'b1;
            end else begin
              we          = 1'b1;
              wdata       = {1'b1, hold};
              wr_spec_n   = wr_spec + 1'b1;
              wr_commit_n = wr_spec + 1'b1;
            end
          end
        end else if (rx_strobe) begin
          if (hold_v && full) begin
            wr_spec_n = wr_commit;
            drop_inc  = 1'b1;
            ovf_n     = 1'b1;
            hold_v_n  = 1'b0;
            state_n   = ST_DROP;
          end else begin
            if (hold_v) begin
              we        = 1'b1;
              wdata     = {1'b0, hold};
              wr_spec_n = wr_spec + 1'b1;
            end
            hold_n   = data_in;
            hold_v_n = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (rx_ready) begin
          state_n  = ST_RECV;
          hold_v_n = 1'b0;
        end else if (rx_eop) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_spec   <= '0;
      wr_commit <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      wr_spec   <= wr_spec_n;
      wr_commit <= wr_commit_n;
      hold      <= hold_n;
      hold_v    <= hold_v_n;
      overflow  <= ovf_n;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Read side: RAM read register acts as the first stage, output register
  // as the second. RAM fetches whenever its register is free or draining.
  assign out_load = rq_v && (!m_tvalid || m_tready);
  assign rd_en    = (rd != wr_commit) && (!rq_v || out_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd       <= '0;
      rq_v     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else begin
      rq_v <= rd_en || (rq_v && !out_load);
      if (rd_en) rd <= rd + 1'b1;
      if (out_load) begin
        m_tvalid <= 1'b1;
        m_tlast  <= rq_data[8];
        m_tdata  <= rq_data[7:0];
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  dpram_rx #(
    .aw(JUMBO_DW),
    .dw(ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_spec[JUMBO_DW-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd[JUMBO_DW-1:0]),
    .rdata (rq_data)
  );

endmodule

// File: tb/tb_client_rx_s.sv
// Testbench for client_rx_s with a 16-byte buffer and a 3-bit drop counter.
module tb_client_rx_s;

  localparam int unsigned JDW  = 4;
  localparam int unsigned CAP  = 16;
  localparam int unsigned CW   = 3;
  localparam int unsigned DMAX = 7;

  logic          clk;
  logic          rst;
  logic          rx_ready;
  logic          rx_strobe;
  logic [7:0]    data_in;
  logic          rx_eop;
  logic          rx_crc_ok;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [CW-1:0] drop_cnt;
  logic          overflow;

  client_rx_s #(.JUMBO_DW(JDW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_strobe (rx_strobe),
    .data_in   (data_in),
    .rx_eop    (rx_eop),
    .rx_crc_ok (rx_crc_ok),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [8:0]  expq[$];
  int          exp_drop = 0;
  int          exp_ovf  = 0;
  int          ovf_seen = 0;
  logic [7:0]  pat[$];
  bit          rand_ready = 1'b0;
  bit          ready_fix  = 1'b1;
  bit          gap_en     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int d);
    return (d > int'(DMAX)) ? int'(DMAX) : d;
  endfunction

  // Sends one packet: rx_ready, len bytes, then (if close) rx_eop with crc.
  // The model decides the fate of the packet from its length, the free room
  // known to the bench, and the CRC verdict.
  task automatic send_pkt(input int unsigned len, input bit crc_ok,
                          input bit close, input bit use_pat);
    logic [7:0] b[$];
    logic [7:0] v;
    int unsigned room;
    room = CAP - expq.size();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    for (int unsigned i = 0; i < len; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      v = use_pat ? pat[i] : 8'($urandom);
      b.push_back(v);
      rx_strobe = 1'b1;
      data_in   = v;
      @(posedge clk); #1;
      rx_strobe = 1'b0;
      data_in   = 8'h00;
    end
    if (close) begin
      rx_eop    = 1'b1;
      rx_crc_ok = crc_ok;
      @(posedge clk); #1;
      rx_eop    = 1'b0;
      rx_crc_ok = 1'b0;
    end
    if (len > 0) begin
      if (!close) begin
        exp_drop++;
      end else if (len > room) begin
        exp_drop++;
        exp_ovf++;
      end else if (!crc_ok) begin
        exp_drop++;
      end else begin
        for (int unsigned i = 0; i < len; i++)
          expq.push_back({(i == len - 1) ? 1'b1 : 1'b0, b[i]});
      end
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_room(input int unsigned max_fill, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (expq.size() > max_fill && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) chk("room_timeout", expq.size(), max_fill);
  endtask

  // Ready driver
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fix;
    end
  end

  // Output monitor: byte order, stability under back-pressure, no gaps
  // inside a committed packet, overflow pulse counting.
  initial begin
    bit         stall_prev;
    bit         fire_prev;
    logic [8:0] stall_val;
    logic [8:0] e;
    stall_prev = 1'b0;
    fire_prev  = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
        fire_prev  = 1'b0;
      end else begin
        if (overflow) ovf_seen++;
        if (stall_prev) begin
          chk("hold_valid", m_tvalid, 1);
          chk("hold_data", {m_tlast, m_tdata}, stall_val);
        end
        if (fire_prev) chk("no_gap", m_tvalid, 1);
        stall_prev = m_tvalid && !m_tready;
        stall_val  = {m_tlast, m_tdata};
        fire_prev  = 1'b0;
        if (m_tvalid && m_tready) begin
          if (expq.size() == 0) begin
            chk("extra_byte", m_tvalid, 0);
          end else begin
            e = expq.pop_front();
            chk("out_byte", {m_tlast, m_tdata}, e);
            fire_prev = !e[8];
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    rx_ready  = 1'b0;
    rx_strobe = 1'b0;
    data_in   = 8'h00;
    rx_eop    = 1'b0;
    rx_crc_ok = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good packet and commit latency
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(4, 1'b1, 1'b1, 1'b1);
    @(negedge clk); chk("lat_n0", m_tvalid, 0);
    @(negedge clk); chk("lat_n1", m_tvalid, 0);
    @(negedge clk); chk("lat_n2", m_tvalid, 1);
    drain(200);
    chk("drop_good", drop_cnt, 0);

    // Bad CRC followed by a good packet
    send_pkt(10, 1'b0, 1'b1, 1'b0);
    send_pkt(3, 1'b1, 1'b1, 1'b0);
    drain(200);
    chk("drop_badcrc", drop_cnt, sat(exp_drop));

    // Overflow with the reader stalled, then an exactly-full packet
    ready_fix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_pkt(20, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_pulses", ovf_seen, exp_ovf);
    chk("drop_ovf", drop_cnt, sat(exp_drop));
    chk("ovf_no_out", m_tvalid, 0);
    send_pkt(16, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("full_pkt_ovf", ovf_seen, exp_ovf);
    ready_fix = 1'b1;
    drain(300);

    // Abort mid-packet, restart immediately with a good 2-byte packet
    send_pkt(5, 1'b1, 1'b0, 1'b0);
    send_pkt(2, 1'b1, 1'b1, 1'b0);
    drain(200);
    chk("drop_abort", drop_cnt, sat(exp_drop));

    // Random back-pressure across pointer wrap, counter saturation
    rand_ready = 1'b1;
    for (int unsigned p = 0; p < 50; p++) begin
      wait_room(CAP - 7, 2000);
      gap_en = ($urandom_range(0, 1) == 1);
      send_pkt(7, $urandom_range(0, 4) != 0, 1'b1, 1'b0);
    end
    gap_en = 1'b0;
    drain(5000);
    rand_ready = 1'b0;
    ready_fix  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("drop_wrap", drop_cnt, sat(exp_drop));
    chk("ovf_wrap", ovf_seen, exp_ovf);

    // Reset with committed data waiting and a packet in flight
    ready_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(6, 1'b1, 1'b1, 1'b0);
    send_pkt(3, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", m_tvalid, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tlast", m_tlast, 0);
    chk("mid_rst_tdata", m_tdata, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_ovf", overflow, 0);
    expq.delete();
    exp_drop  = 0;
    ready_fix = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_pkt(5, 1'b1, 1'b1, 1'b0);
    drain(200);
    send_pkt(4, 1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_drop", drop_cnt, sat(exp_drop));
    chk("post_rst_idle", m_tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
